// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes engine: LANES bytes per cycle, result held until accepted downstream.
// Define SUB_BYTES_FWD_EN to build the forward S-box and honour in_inv=0; otherwise inverse only.
module sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned BEATS = 16 / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Entry v lives at bits [2047-8v -: 8]
    localparam logic [2047:0] INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return INV_TBL[idx +: 8];
    endfunction

`ifdef SUB_BYTES_FWD_EN
    localparam logic [2047:0] FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return FWD_TBL[idx +: 8];
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [127:0]       r_work;
    logic               r_mode;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_load_mode;
    logic [127:0]       w_next_work;
    logic [LANES-1:0][7:0] w_lane_out;

`ifdef SUB_BYTES_FWD_EN
    assign w_load_mode = in_inv;
`else
    // Inverse-only build: in_inv and the mode register carry no information
    logic [1:0] w_unused_cfg;
    assign w_unused_cfg = {in_inv, r_mode};
    assign w_load_mode  = 1'b1;
`endif

    assign w_in_ready = !rst && ((r_state == IDLE) || ((r_state == HOLD) && out_ready));
    assign w_accept   = in_valid && w_in_ready;
    assign w_last     = (r_cnt == CNT_W'(BEATS - 1));

    // One S-box lookup per lane on the bytes of the current beat
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] w_pos;
        logic [6:0] w_off;
        logic [7:0] w_in;
        assign w_pos = 4'(r_cnt * LANES + l);
        assign w_off = {~w_pos, 3'b000};
        assign w_in  = r_work[w_off +: 8];
`ifdef SUB_BYTES_FWD_EN
        assign w_lane_out[l] = r_mode ? inv_sbox(w_in) : fwd_sbox(w_in);
`else
        assign w_lane_out[l] = inv_sbox(w_in);
`endif
    end

    // Byte k is rewritten only in the beat that owns it
    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign w_next_work[(15-k)*8 +: 8] = (r_cnt == CNT_W'(k / LANES))
                                          ? w_lane_out[k % LANES]
                                          : r_work[(15-k)*8 +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_mode      <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_work  <= in_data;
                        r_mode  <= w_load_mode;
                        r_cnt   <= '0;
                        r_state <= SUB;
                        r_busy  <= 1'b1;
                    end
                end
                SUB: begin
                    r_work <= w_next_work;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_state     <= HOLD;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Drain and reload in the same cycle keeps throughput at BEATS+1
                    if (w_accept) begin
                        r_work      <= in_data;
                        r_mode      <= w_load_mode;
                        r_cnt       <= '0;
                        r_state     <= SUB;
                        r_out_valid <= 1'b0;
                    end else if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? r_work : 128'h0;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: five instances at LANES = 4, 1, 8, 2, 16.
module tb_sub_bytes_seq;

    localparam int N = 5;
    localparam logic [127:0] SEQ     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_INV = 128'h52096ad53036a538bf40a39e81f3d7fb;
`ifdef SUB_BYTES_FWD_EN
    localparam logic [7:0] ZERO_FWD = 8'h63;
`else
    localparam logic [7:0] ZERO_FWD = 8'h52;
`endif

    function automatic int lanes_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            3:       return 2;
            default: return 16;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [127:0] in_data  [N];
    logic [127:0] out_data [N];
    int xfers [N] = '{default: 0};
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sub_bytes_seq #(.LANES(lanes_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    always @(posedge clk) begin
        for (int u = 0; u < N; u++)
            if (out_valid[u] && out_ready[u]) xfers[u] <= xfers[u] + 1;
    end

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept one block, flip in_inv afterwards, and count edges until out_valid
    task automatic send(input int u, input logic [127:0] d, input logic inv, output int lat);
        @(negedge clk);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_inv[u]   = inv;
        #1 check_bit("accept_ready", in_ready[u], 1'b1);
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        in_inv[u]   = ~inv;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid[u] && lat < 40);
    endtask

    task automatic drain(input int u);
        int x0;
        x0 = xfers[u];
        out_ready[u] = 1'b1;
        @(negedge clk);
        out_ready[u] = 1'b0;
        check_bit("drain_valid", out_valid[u], 1'b0);
        check_int("drain_xfers", xfers[u] - x0, 1);
        check_bit("drain_busy", busy[u], 1'b0);
    endtask

    initial begin
        int lat;
        logic seen;
        in_valid  = '0;
        in_inv    = '0;
        out_ready = '0;
        for (int u = 0; u < N; u++) in_data[u] = '0;

        // Reset values while rst is held
        repeat (2) @(negedge clk);
        for (int u = 0; u < N; u++) begin
            check_bit("rst_out_valid", out_valid[u], 1'b0);
            check("rst_out_data", out_data[u], 128'h0);
            check_bit("rst_busy", busy[u], 1'b0);
            check_bit("rst_in_ready", in_ready[u], 1'b0);
        end
        rst = 1'b0;
        #1 check("rel_in_ready", 128'(in_ready), 128'(5'b11111));

        // LANES=4 inverse of all 0x63
        send(0, rep(8'h63), 1'b1, lat);
        check_int("l4_latency", lat, 4);
        check("l4_data", out_data[0], 128'h0);
        drain(0);

        // LANES=1 inverse of 00..0f
        send(1, SEQ, 1'b1, lat);
        check_int("l1_latency", lat, 16);
        check("l1_data", out_data[1], SEQ_INV);

        // Backpressure: result held, in_valid pulses ignored
        for (int i = 0; i < 10; i++) begin
            in_valid[1] = (i % 2) == 0;
            in_data[1]  = rep(8'(i + 1));
            @(negedge clk);
            check_bit("bp_valid", out_valid[1], 1'b1);
            check("bp_data", out_data[1], SEQ_INV);
            check_bit("bp_in_ready", in_ready[1], 1'b0);
        end
        in_valid[1] = 1'b0;
        drain(1);
        repeat (3) @(negedge clk);
        check_bit("bp_no_queue", out_valid[1], 1'b0);

        // Back-to-back LANES=8 with out_ready tied high
        out_ready[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b1;
        in_data[2]  = rep(8'h7c);
        in_inv[2]   = 1'b1;
        @(negedge clk);
        in_data[2] = rep(8'hff);
        check_bit("b2b_c1_valid", out_valid[2], 1'b0);
        @(negedge clk);
        check_bit("b2b_c2_valid", out_valid[2], 1'b0);
        @(negedge clk);
        check_bit("b2b_a_valid", out_valid[2], 1'b1);
        check("b2b_a_data", out_data[2], rep(8'h01));
        check_bit("b2b_a_in_ready", in_ready[2], 1'b1);
        @(negedge clk);
        in_valid[2] = 1'b0;
        check_bit("b2b_reload_valid", out_valid[2], 1'b0);
        check_bit("b2b_reload_busy", busy[2], 1'b1);
        @(negedge clk);
        check_bit("b2b_c5_valid", out_valid[2], 1'b0);
        @(negedge clk);
        check_bit("b2b_b_valid", out_valid[2], 1'b1);
        check("b2b_b_data", out_data[2], rep(8'h7d));
        @(negedge clk);
        check_bit("b2b_end_valid", out_valid[2], 1'b0);
        check_bit("b2b_end_busy", busy[2], 1'b0);
        check_int("b2b_xfers", xfers[2], 2);
        out_ready[2] = 1'b0;

        // LANES=16 single-cycle, in_inv=0 on zero data, then inverse pattern
        send(4, 128'h0, 1'b0, lat);
        check_int("l16_latency", lat, 1);
        check("l16_fwd_data", out_data[4], rep(ZERO_FWD));
        drain(4);
        send(4, SEQ, 1'b1, lat);
        check("l16_inv_data", out_data[4], SEQ_INV);
        drain(4);

        // in_inv flips to 0 after accept; mode must stay inverse
        send(0, 128'h0, 1'b1, lat);
        check("l4_mode_latched", out_data[0], rep(8'h52));
        drain(0);

        // Reset in the 2nd SUB cycle on LANES=2
        @(negedge clk);
        in_valid[3] = 1'b1;
        in_data[3]  = SEQ;
        in_inv[3]   = 1'b1;
        @(posedge clk);
        #1 in_valid[3] = 1'b0;
        @(negedge clk);
        check_bit("rs_sub_busy", busy[3], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_bit("rs_busy", busy[3], 1'b0);
        check_bit("rs_valid", out_valid[3], 1'b0);
        check("rs_data", out_data[3], 128'h0);
        check_bit("rs_in_ready", in_ready[3], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_bit("rs_rel_ready", in_ready[3], 1'b1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | out_valid[3];
        end
        check_bit("rs_no_stale", seen, 1'b0);

        // Reset while a LANES=8 result sits in HOLD
        send(2, rep(8'hff), 1'b1, lat);
        check_int("rh_latency", lat, 2);
        rst = 1'b1;
        #1;
        check_bit("rh_valid", out_valid[2], 1'b0);
        check("rh_data", out_data[2], 128'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | out_valid[2];
        end
        check_bit("rh_no_stale", seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
